ysyx_exu_sys: RTL
=================

# ysyx_exu_sys

System-instruction sequencer in the backend, acting as the initiator that drives the CSR register file. It accepts one CSR or trap instruction (csrrw/rs/rc and immediate forms, ecall, mret) from the execute stage. It waits for the store queue to drain, then issues a single-cycle access to the CSR file and returns the old CSR value to writeback. For ecall and mret, it redirects fetch to mtvec or mepc and flushes the pipeline.

## Interface
Parameters:
- XLEN, `YSYX_XLEN (32): data width.
- R_W, 12: CSR address width.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  EXU presents a system instruction.
- out_ready  out  1  sequencer can accept; equals (state==IDLE).
- in_funct3  in  3  CSR op: 001 rw, 010 rs, 011 rc, 101 rwi, 110 rsi, 111 rci.
- in_ecall / in_mret  in  1 each  trap-class instruction flags.
- in_csr_addr  in  R_W  CSR address.
- in_rs1_val  in  XLEN  rs1 operand.
- in_rs1_idx  in  5  rs1 index, or zimm for immediate forms.
- in_pc  in  XLEN  instruction PC.
- in_sq_empty  in  1  no outstanding stores.
- csr_valid, csr_wen, csr_ecall, csr_mret  out  1 each  CSR file strobes.
- csr_rwaddr  out  R_W  CSR address.
- csr_wdata  out  XLEN  CSR write data.
- csr_pc  out  XLEN  PC for mepc.
- csr_rdata, csr_mtvec, csr_mepc  in  XLEN  CSR file read data, combinational.
- out_valid  out  1  rd result valid.
- in_ready  in  1  WBU accepts the result.
- out_rd_data  out  XLEN  old CSR value.
- out_redirect_valid  out  1  fetch redirect request.
- out_redirect_pc  out  XLEN  redirect target.
- in_redirect_ready  in  1  IFU accepts the redirect.
- out_flush  out  1  one-cycle pipeline flush.

## Operation
- States: IDLE, DRAIN, COMMIT, RESP, REDIR.
- **IDLE:** when in_valid && out_ready, latch funct3, ecall, mret, addr, rs1_val, rs1_idx and pc, then go to DRAIN.
- **DRAIN:** hold until in_sq_empty=1, then go to COMMIT. Minimum stay is 1 cycle.
- **COMMIT:** lasts exactly 1 cycle.
  - Outputs: csr_valid=1, csr_rwaddr=latched addr, csr_pc=latched pc.
  - Latch csr_rdata into out_rd_data.
  - Operand src = funct3[2] ? zero-extended rs1_idx : rs1_val.
  - wdata: rw gives src; rs gives rdata|src; rc gives rdata&~src.
  - csr_wen: 1 for rw/rwi; 1 for rs/rc and their immediate forms only when rs1_idx!=0.
  - funct3 000 or 100 gives csr_wen=0.
- **Trap precedence:** ecall overrides mret and any CSR op.
  - ecall: csr_ecall=1, csr_wen=0; latch csr_mtvec as target.
  - mret: csr_mret=1, csr_wen=0; latch csr_mepc as target.
  - Targets are sampled in COMMIT, before the CSR update lands.
- **Leaving COMMIT:** trap goes to REDIR; otherwise goes to RESP.
- **RESP:** out_valid=1; when in_ready, go to IDLE.
- **REDIR:** out_redirect_valid=1 with out_redirect_pc=target.
  - On in_redirect_ready, out_flush=1 in that same cycle, then go to IDLE.
  - Traps produce no rd result (out_valid is never asserted).
- **Reset values:** state=IDLE; all csr_* strobes, out_valid, out_redirect_valid and out_flush are 0; out_ready=1; data outputs are 0.
- **Reset mid-operation:** the instruction is dropped and no further csr_valid pulse occurs for it.

## Timing
- Accept at cycle T: DRAIN at T+1; COMMIT at T+1+d, where d ≥ 1 is the number of cycles until in_sq_empty.
- With sq_empty high: COMMIT at T+2; RESP or REDIR from T+3.
- Best-case throughput is one instruction per 4 cycles; out_ready is 0 outside IDLE.
- csr_valid is asserted for exactly one cycle per accepted instruction, never twice.
- out_valid and out_redirect_valid hold their data stable until their handshake completes.
- in_sq_empty dropping back to 0 has no effect once in COMMIT or later.

## Test plan
- **csrrw:** mtvec (0x305) starts at 0; csrrw with rs1_val=0x80000100, sq_empty=1.
  - COMMIT at T+2: csr_wen=1, wdata=0x80000100.
  - RESP at T+3: out_rd_data=0.
- **csrrs, rs1=x0:** mstatus=0x1800; csrrs with rs1_idx=0.
  - csr_wen=0; out_rd_data=0x1800.
- **csrrci:** mstatus=0x1888; zimm=0x8.
  - wdata=0x1880; out_rd_data=0x1888.
- **ecall:** mtvec=0x80000100, pc=0x80000040.
  - COMMIT: csr_ecall=1, csr_pc=0x80000040.
  - REDIR: out_redirect_pc=0x80000100.
  - in_redirect_ready asserted at T+5 gives out_flush=1 at T+5.
- **Drain stall then mret:** sq_empty=0 for 3 cycles, mepc=0x80000044, mret issued.
  - COMMIT delayed to T+4 with csr_mret=1.
  - Redirect target = 0x80000044.
  - Assert in_ecall and in_mret together: ecall wins and the target is mtvec.
- **Reset mid-operation:** drop reset to 0 during DRAIN.
  - Immediately: out_ready=1 and all strobes 0.
  - After release: no csr_valid pulse occurs; a new csrrw then completes normally.

Source files
------------

// File: rtl/ysyx_exu_sys.sv
// System-instruction sequencer: drains stores, makes one CSR-file access per
// CSR/trap instruction, then returns the old CSR value or redirects fetch.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_exu_sys #(
  parameter int XLEN = `YSYX_XLEN,
  parameter int R_W  = 12
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            out_ready,
  input  logic [2:0]      in_funct3,
  input  logic            in_ecall,
  input  logic            in_mret,
  input  logic [R_W-1:0]  in_csr_addr,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [4:0]      in_rs1_idx,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_sq_empty,
  output logic            csr_valid,
  output logic            csr_wen,
  output logic            csr_ecall,
  output logic            csr_mret,
  output logic [R_W-1:0]  csr_rwaddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_pc,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  output logic            out_valid,
  input  logic            in_ready,
  output logic [XLEN-1:0] out_rd_data,
  output logic            out_redirect_valid,
  output logic [XLEN-1:0] out_redirect_pc,
  input  logic            in_redirect_ready,
  output logic            out_flush,
  output logic [2:0]      dbg_state
);

  // Handshakes: a transfer happens in a cycle where valid and ready are both
  // high; valid and its data stay stable until that cycle.
  typedef enum logic [2:0] {IDLE, DRAIN, COMMIT, RESP, REDIR} state_t;

  state_t          state, state_nxt;
  logic [2:0]      funct3_q;
  logic            ecall_q, mret_q;
  logic [R_W-1:0]  addr_q;
  logic [XLEN-1:0] rs1_val_q, pc_q, rd_q, target_q;
  logic [4:0]      rs1_idx_q;
  logic [XLEN-1:0] src;
  logic            trap;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      funct3_q  <= '0;
      ecall_q   <= 1'b0;
      mret_q    <= 1'b0;
      addr_q    <= '0;
      rs1_val_q <= '0;
      rs1_idx_q <= '0;
      pc_q      <= '0;
      rd_q      <= '0;
      target_q  <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        funct3_q  <= in_funct3;
        ecall_q   <= in_ecall;
        mret_q    <= in_mret;
        addr_q    <= in_csr_addr;
        rs1_val_q <= in_rs1_val;
        rs1_idx_q <= in_rs1_idx;
        pc_q      <= in_pc;
      end
      // Targets are captured from the pre-update CSR values.
      if (state == COMMIT) begin
        rd_q <= csr_rdata;
        if (ecall_q)     target_q <= csr_mtvec;
        else if (mret_q) target_q <= csr_mepc;
      end
    end
  end

  assign src  = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_val_q;
  assign trap = ecall_q | mret_q;

  always_comb begin
    state_nxt          = state;
    csr_valid          = 1'b0;
    csr_wen            = 1'b0;
    csr_ecall          = 1'b0;
    csr_mret           = 1'b0;
    csr_rwaddr         = '0;
    csr_wdata          = '0;
    csr_pc             = '0;
    out_valid          = 1'b0;
    out_redirect_valid = 1'b0;
    out_flush          = 1'b0;
    case (state)
      IDLE:  if (in_valid) state_nxt = DRAIN;
      DRAIN: if (in_sq_empty) state_nxt = COMMIT;
      COMMIT: begin
        csr_valid  = 1'b1;
        csr_rwaddr = addr_q;
        csr_pc     = pc_q;
        if (ecall_q)     csr_ecall = 1'b1;
        else if (mret_q) csr_mret  = 1'b1;
        else begin
          case (funct3_q[1:0])
            2'b01: begin csr_wen = 1'b1;               csr_wdata = src;              end
            2'b10: begin csr_wen = (rs1_idx_q != 5'd0); csr_wdata = csr_rdata | src;  end
            2'b11: begin csr_wen = (rs1_idx_q != 5'd0); csr_wdata = csr_rdata & ~src; end
            default: ;
          endcase
        end
        state_nxt = trap ? REDIR : RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        if (in_ready) state_nxt = IDLE;
      end
      REDIR: begin
        out_redirect_valid = 1'b1;
        if (in_redirect_ready) begin
          out_flush = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign out_ready       = (state == IDLE);
  assign out_rd_data     = rd_q;
  assign out_redirect_pc = target_q;
  assign dbg_state       = state;

endmodule
